// File: rtl/cache.sv
// L2 cache model: 16384 sets x 8 ways, MESI coherence, tree pseudo-LRU, one command resolved per clock.
// Define CACHE_TRACE_EN to print a line per processed command.
package cache_pkg;
   localparam int NUM_OF_SETS = 16384;
   localparam int WAYS        = 8;
   localparam int WAYS_REP    = WAYS - 1;
   localparam int LINE_BYTES  = 64;
   localparam int OFF_W       = $clog2(LINE_BYTES);
   localparam int IDX_W       = $clog2(NUM_OF_SETS);
   localparam int TAG_W       = 32 - IDX_W - OFF_W;

   typedef enum logic [1:0] {I = 2'd0, S = 2'd1, E = 2'd2, M = 2'd3} mesi_e;
   typedef struct packed {
      mesi_e             mesi;
      logic [TAG_W-1:0]  tag;
   } line_t;
   typedef struct packed {
      line_t [WAYS-1:0] line;
   } sets_nway_t;

   typedef enum logic [2:0] {NOP = 3'd0, READ = 3'd1, WRITE = 3'd2, INVALIDATE = 3'd3, RWIM = 3'd4} bus_e;
   typedef enum logic [2:0] {NOMSG = 3'd0, GETLINE = 3'd1, SENDLINE = 3'd2, INVALIDATELINE = 3'd3,
                             EVICTLINE = 3'd4} l2tol1_e;
   typedef struct packed { bus_e bus; } bus_func_t;
   typedef struct packed { l2tol1_e l2tol1; } l2tol1_t;
endpackage

module cache
   import cache_pkg::*;
(
   input  logic              clk,
   input  logic              rstb,
   input  logic [31:0]       address,
   input  logic [3:0]        n,
   input  logic              valid,
   output logic [15:0]       hit_cntr,
   output logic [15:0]       miss_cntr,
   output bus_func_t         bus_func_out,
   output l2tol1_t           l2tol1msg_out,
   output logic [1:0]        C,
   output sets_nway_t        sets [NUM_OF_SETS]
);
   localparam int LVLS = $clog2(WAYS);
   localparam int NW   = (WAYS_REP > 1) ? $clog2(WAYS_REP) : 1;

   logic [IDX_W-1:0]    idx;
   logic [TAG_W-1:0]    tag;
   logic                unused_addr_bits;
   assign idx = address[OFF_W +: IDX_W];
   assign tag = address[31 -: TAG_W];
   assign unused_addr_bits = ^address[OFF_W-1:2];

   sets_nway_t          sets_q [NUM_OF_SETS];
   logic [WAYS_REP-1:0] plru_q [NUM_OF_SETS];
   sets_nway_t          cur_set, set_d;
   logic [WAYS_REP-1:0] cur_plru, plru_d;
   logic [15:0]         hit_q, hit_d, miss_q, miss_d;
   bus_e                bus_q, bus_d;
   l2tol1_e             msg_q, msg_d;
   logic [1:0]          c_q, c_d;
   logic [WAYS_REP-1:0] ways_in_q, ways_in_d, ways_in;
   logic                wr_en, clear;
   logic [WAYS-1:0]     hit_vec, inv_vec;
   logic                hit_any;
   logic [LVLS-1:0]     hit_way, victim_way, use_way;
   mesi_e               hit_mesi;

   assign cur_set  = sets_q[idx];
   assign cur_plru = plru_q[idx];
   assign ways_in  = ways_in_q;

   generate
      for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
         assign hit_vec[gi] = (cur_set.line[gi].mesi != I) && (cur_set.line[gi].tag == tag);
         assign inv_vec[gi] = (cur_set.line[gi].mesi == I);
      end
   endgenerate

   // Walk from the root: a 0 bit steers left, path bits form the way index MSB first.
   function automatic logic [LVLS-1:0] plru_victim(input logic [WAYS_REP-1:0] t);
      logic [NW-1:0]   node;
      logic [LVLS-1:0] way;
      node = '0;
      way  = '0;
      for (int l = 0; l < LVLS; l++) begin
         way[LVLS-1-l] = t[node];
         node = NW'(32'(node) * 2 + 1 + 32'(t[node]));
      end
      return way;
   endfunction

   function automatic logic [WAYS_REP-1:0] plru_touch(input logic [WAYS_REP-1:0] t,
                                                      input logic [LVLS-1:0] way);
      logic [NW-1:0]       node;
      logic [WAYS_REP-1:0] r;
      logic                dir;
      r    = t;
      node = '0;
      for (int l = 0; l < LVLS; l++) begin
         dir     = way[LVLS-1-l];
         r[node] = ~dir;
         node    = NW'(32'(node) * 2 + 1 + 32'(dir));
      end
      return r;
   endfunction

   always_comb begin
      hit_way    = '0;
      victim_way = plru_victim(cur_plru);
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (hit_vec[w]) hit_way = LVLS'(w);
         if (inv_vec[w]) victim_way = LVLS'(w);
      end
      hit_any  = |hit_vec;
      hit_mesi = cur_set.line[hit_way].mesi;
   end

   always_comb begin
      set_d     = cur_set;
      plru_d    = cur_plru;
      hit_d     = hit_q;
      miss_d    = miss_q;
      bus_d     = bus_q;
      msg_d     = msg_q;
      c_d       = c_q;
      ways_in_d = ways_in_q;
      wr_en     = 1'b0;
      clear     = 1'b0;
      use_way   = hit_any ? hit_way : victim_way;
      if (valid) begin
         case (n)
            4'd0, 4'd1, 4'd2: begin
               wr_en = 1'b1;
               if (hit_any) begin
                  hit_d = hit_q + 16'd1;
                  bus_d = NOP;
                  if (n == 4'd1) begin
                     msg_d = NOMSG;
                     if (hit_mesi == S) bus_d = INVALIDATE;
                     set_d.line[use_way].mesi = M;
                  end else begin
                     msg_d = SENDLINE;
                  end
               end else begin
                  miss_d = miss_q + 16'd1;
                  msg_d  = (cur_set.line[use_way].mesi != I) ? EVICTLINE : SENDLINE;
                  set_d.line[use_way].tag = tag;
                  if (n == 4'd1) begin
                     bus_d = RWIM;
                     set_d.line[use_way].mesi = M;
                  end else begin
                     // address[1] set means no other cache holds the line
                     bus_d = READ;
                     set_d.line[use_way].mesi = address[1] ? E : S;
                  end
               end
               plru_d    = plru_touch(cur_plru, use_way);
               ways_in_d = plru_d;
            end
            4'd3, 4'd4, 4'd5, 4'd6: begin
               wr_en     = 1'b1;
               ways_in_d = cur_plru;
               bus_d     = NOP;
               msg_d     = NOMSG;
               if (!hit_any)        c_d = 2'b10;
               else if (hit_mesi == M) c_d = 2'b01;
               else                 c_d = 2'b00;
               if (hit_any) begin
                  case (n)
                     4'd3: if (hit_mesi == S) begin
                        set_d.line[hit_way].mesi = I;
                        msg_d = INVALIDATELINE;
                     end
                     4'd4: begin
                        if (hit_mesi == M) begin
                           bus_d = WRITE;
                           msg_d = GETLINE;
                        end
                        set_d.line[hit_way].mesi = S;
                     end
                     4'd6: begin
                        if (hit_mesi == M) begin
                           bus_d = WRITE;
                           msg_d = EVICTLINE;
                        end else begin
                           msg_d = INVALIDATELINE;
                        end
                        set_d.line[hit_way].mesi = I;
                     end
                     default: ;
                  endcase
               end
            end
            4'd8: clear = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rstb || clear) begin
         for (int i = 0; i < NUM_OF_SETS; i++) begin
            sets_q[i] <= '0;
            plru_q[i] <= '0;
         end
         hit_q     <= '0;
         miss_q    <= '0;
         bus_q     <= NOP;
         msg_q     <= NOMSG;
         c_q       <= 2'b10;
         ways_in_q <= '0;
      end else begin
         if (wr_en) begin
            sets_q[idx] <= set_d;
            plru_q[idx] <= plru_d;
         end
         hit_q     <= hit_d;
         miss_q    <= miss_d;
         bus_q     <= bus_d;
         msg_q     <= msg_d;
         c_q       <= c_d;
         ways_in_q <= ways_in_d;
      end
   end

`ifdef CACHE_TRACE_EN
   always_ff @(posedge clk) begin
      if (!rstb && valid)
         $display("cache: n=%0d addr=%h bus=%s l2tol1=%s C=%b",
                  n, address, bus_d.name(), msg_d.name(), c_d);
   end
`else
`endif

   assign hit_cntr             = hit_q;
   assign miss_cntr            = miss_q;
   assign bus_func_out.bus     = bus_q;
   assign l2tol1msg_out.l2tol1 = msg_q;
   assign C                    = c_q;
   assign sets                 = sets_q;
endmodule

// File: tb/tb_cache.sv
// Directed bench for cache: hand-computed expectations for fills, hits, snoops, PLRU and clear.
module tb_cache;
   import cache_pkg::*;

   logic        clk = 1'b0;
   logic        rstb;
   logic [31:0] address;
   logic [3:0]  n;
   logic        valid;
   logic [15:0] hit_cntr, miss_cntr;
   bus_func_t   bus_func_out;
   l2tol1_t     l2tol1msg_out;
   logic [1:0]  c_res;
   sets_nway_t  sets [NUM_OF_SETS];

   int n_cmp = 0;
   int n_bad = 0;

   cache dut (
      .clk(clk), .rstb(rstb), .address(address), .n(n), .valid(valid),
      .hit_cntr(hit_cntr), .miss_cntr(miss_cntr), .bus_func_out(bus_func_out),
      .l2tol1msg_out(l2tol1msg_out), .C(c_res), .sets(sets)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic send(input logic [3:0] cmd, input logic [31:0] a);
      @(negedge clk);
      n       = cmd;
      address = a;
      valid   = 1'b1;
      @(negedge clk);
      valid   = 1'b0;
   endtask

   task automatic check_outs(input string tag, input logic [15:0] h, input logic [15:0] m,
                             input bus_e b, input l2tol1_e g);
      check({tag, ".hit"},  32'(hit_cntr), 32'(h));
      check({tag, ".miss"}, 32'(miss_cntr), 32'(m));
      check({tag, ".bus"},  32'(bus_func_out.bus), 32'(b));
      check({tag, ".msg"},  32'(l2tol1msg_out.l2tol1), 32'(g));
   endtask

   initial begin
      int bad_lines;
      rstb = 1'b1; valid = 1'b0; n = '0; address = '0;
      repeat (2) @(negedge clk);
      rstb = 1'b0;

      check_outs("reset", 16'd0, 16'd0, NOP, NOMSG);
      check("reset.C", 32'(c_res), 32'h2);
      check("reset.mesi", 32'(sets[0].line[0].mesi), 32'(I));

      // Read miss, others HIT -> shared fill into way 0
      send(4'd0, 32'h1000_0000);
      check_outs("rd_miss", 16'd0, 16'd1, READ, SENDLINE);
      check("rd_miss.mesi", 32'(sets[0].line[0].mesi), 32'(S));
      check("rd_miss.tag", 32'(sets[0].line[0].tag), 32'h100);
      send(4'd0, 32'h1000_0000);
      check_outs("rd_hit", 16'd1, 16'd1, NOP, SENDLINE);

      // Write miss -> RWIM, modified fill into way 1
      send(4'd1, 32'h0000_0002);
      check_outs("wr_miss", 16'd1, 16'd2, RWIM, SENDLINE);
      check("wr_miss.mesi", 32'(sets[0].line[1].mesi), 32'(M));
      send(4'd4, 32'h0000_0002);
      check("snp_rd.C", 32'(c_res), 32'h1);
      check_outs("snp_rd", 16'd1, 16'd2, WRITE, GETLINE);
      check("snp_rd.mesi", 32'(sets[0].line[1].mesi), 32'(S));
      send(4'd1, 32'h0000_0002);
      check_outs("wr_hit_s", 16'd2, 16'd2, INVALIDATE, NOMSG);
      check("wr_hit_s.mesi", 32'(sets[0].line[1].mesi), 32'(M));

      // Ignored commands hold everything
      send(4'd9, 32'h0000_0002);
      check_outs("print", 16'd2, 16'd2, INVALIDATE, NOMSG);
      send(4'd7, 32'h0000_0002);
      check_outs("cmd7", 16'd2, 16'd2, INVALIDATE, NOMSG);
      check("cmd7.mesi", 32'(sets[0].line[1].mesi), 32'(M));
      check("cmd7.C", 32'(c_res), 32'h1);

      send(4'd8, 32'h0);
      check_outs("clear", 16'd0, 16'd0, NOP, NOMSG);
      check("clear.C", 32'(c_res), 32'h2);
      bad_lines = 0;
      for (int i = 0; i < NUM_OF_SETS; i++)
         for (int j = 0; j < WAYS; j++)
            if (sets[i].line[j].mesi != I) bad_lines++;
      check("clear.all_inv", 32'(bad_lines), 32'd0);

      // Exclusive fill, then snoops
      send(4'd0, 32'h0000_0003);
      check_outs("rd_excl", 16'd0, 16'd1, READ, SENDLINE);
      check("rd_excl.mesi", 32'(sets[0].line[0].mesi), 32'(E));
      send(4'd5, 32'h0000_0003);
      check("snp_wr.C", 32'(c_res), 32'h0);
      check("snp_wr.mesi", 32'(sets[0].line[0].mesi), 32'(E));
      send(4'd3, 32'h0040_0000);
      check("snp_inv_miss.C", 32'(c_res), 32'h2);
      send(4'd6, 32'h0000_0003);
      check("rwim.C", 32'(c_res), 32'h0);
      check_outs("rwim", 16'd0, 16'd1, NOP, INVALIDATELINE);
      check("rwim.mesi", 32'(sets[0].line[0].mesi), 32'(I));
      send(4'd0, 32'h0000_0003);
      send(4'd1, 32'h0000_0003);
      check_outs("wr_hit_e", 16'd1, 16'd2, NOP, NOMSG);
      check("wr_hit_e.mesi", 32'(sets[0].line[0].mesi), 32'(M));

      // PLRU: fill all eight ways of set 0, then force a replacement
      send(4'd8, 32'h0);
      for (int k = 0; k < 8; k++) begin
         send(4'd0, 32'(k) << 20);
         if (k == 3) check("plru.k3", 32'(dut.ways_in), 32'h01);
      end
      check("plru.full", 32'(dut.ways_in), 32'h00);
      send(4'd0, 32'(8) << 20);
      check_outs("evict", 16'd0, 16'd9, READ, EVICTLINE);
      check("evict.plru", 32'(dut.ways_in), 32'h0B);
      check("evict.tag", 32'(sets[0].line[0].tag), 32'h8);
      check("evict.way7", 32'(sets[0].line[7].tag), 32'h7);

      // Reset overrides a simultaneous command
      @(negedge clk);
      rstb = 1'b1; valid = 1'b1; n = 4'd0; address = 32'h0050_0000;
      @(negedge clk);
      rstb = 1'b0; valid = 1'b0;
      check_outs("rst_valid", 16'd0, 16'd0, NOP, NOMSG);
      check("rst_valid.C", 32'(c_res), 32'h2);
      check("rst_valid.mesi", 32'(sets[0].line[0].mesi), 32'(I));
      check("rst_valid.plru", 32'(dut.ways_in), 32'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
